// File: rtl/mbr_seq.sv
// Memory buffer register with a RAM access sequencer (IDLE/READ/WRITE).
// Define MBR_PARITY_EN to add RAM parity generation and checking.
module mbr_seq #(
    parameter int DATA_W  = 16,
    parameter int CON_W   = 32,
    parameter int RD_BIT  = 4,
    parameter int LDA_BIT = 11,
    parameter int WR_BIT  = 12,
    parameter int RD_WAIT = 1,
    parameter int WR_HOLD = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CON_W-1:0]  CON,
    input  logic [DATA_W-1:0] RAM_IN,
    input  logic [DATA_W-1:0] ACC_IN,
    output logic [DATA_W-1:0] MBR_OUT,
    output logic              R_W,
    output logic              MEM_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic              DROPPED
`ifdef MBR_PARITY_EN
    ,
    input  logic              RAM_PAR_IN,
    output logic              RAM_PAR_OUT,
    output logic              PAR_ERR
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_HOLD - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] mbr_nxt;
    logic              r_w_nxt, mem_en_nxt, busy_nxt, done_nxt, dropped_nxt;

    logic rd_cmd, lda_cmd, wr_cmd;
    assign rd_cmd  = CON[RD_BIT];
    assign lda_cmd = CON[LDA_BIT];
    assign wr_cmd  = CON[WR_BIT];

    // Only three CON bits are decoded; the rest are deliberately ignored.
    logic unused_con;
    assign unused_con = ^CON;

`ifdef MBR_PARITY_EN
    logic par_err_nxt;
    assign RAM_PAR_OUT = ^MBR_OUT;
`endif

    // NOTE: every next-value is defaulted before the case so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mbr_nxt     = MBR_OUT;
        r_w_nxt     = R_W;
        mem_en_nxt  = MEM_EN;
        busy_nxt    = BUSY;
        done_nxt    = 1'b0;
        dropped_nxt = 1'b0;
`ifdef MBR_PARITY_EN
        par_err_nxt = PAR_ERR;
`endif
        case (state)
            IDLE: begin
                if (wr_cmd) begin
                    state_nxt   = WRITE;
                    cnt_nxt     = WR_LOAD;
                    r_w_nxt     = 1'b1;
                    mem_en_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    // Forwarded ACC value is what gets written.
                    if (lda_cmd) mbr_nxt = ACC_IN;
                    dropped_nxt = rd_cmd;
                end else if (rd_cmd) begin
                    state_nxt   = READ;
                    cnt_nxt     = RD_LOAD;
                    r_w_nxt     = 1'b0;
                    mem_en_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    dropped_nxt = lda_cmd;
                end else if (lda_cmd) begin
                    mbr_nxt  = ACC_IN;
                    done_nxt = 1'b1;
                end
            end
            READ: begin
                dropped_nxt = rd_cmd | lda_cmd | wr_cmd;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt  = IDLE;
                    mbr_nxt    = RAM_IN;
                    mem_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
`ifdef MBR_PARITY_EN
                    par_err_nxt = (^RAM_IN) ^ RAM_PAR_IN;
`endif
                end
            end
            WRITE: begin
                dropped_nxt = rd_cmd | lda_cmd | wr_cmd;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt  = IDLE;
                    r_w_nxt    = 1'b0;
                    mem_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            MBR_OUT <= '0;
            R_W     <= 1'b0;
            MEM_EN  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DROPPED <= 1'b0;
`ifdef MBR_PARITY_EN
            PAR_ERR <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            MBR_OUT <= mbr_nxt;
            R_W     <= r_w_nxt;
            MEM_EN  <= mem_en_nxt;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
            DROPPED <= dropped_nxt;
`ifdef MBR_PARITY_EN
            PAR_ERR <= par_err_nxt;
`endif
        end
    end

endmodule
